// File: rtl/spw_babasu_pkg.sv
// Shared definitions for the SpaceWire TX push port: register map,
// status bit layout and the token format.
package spw_babasu_pkg;

  localparam logic [1:0] ADDR_TXDATA = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_FLUSH  = 2'd2;
  localparam logic [1:0] ADDR_OVF    = 2'd3;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_LVL_LSB = 8;

  localparam int TOKEN_W = 9;

  typedef struct packed {
    logic       flag;
    logic [7:0] data;
  } token_t;

  // Token layout mirrors the Avalon write word: flag in bit 8, data below.
  function automatic token_t token_from_word(input logic [TOKEN_W-1:0] w);
    token_t t;
    t.flag = w[8];
    t.data = w[7:0];
    return t;
  endfunction

endpackage

// File: rtl/spw_babasu_sync_fifo.sv
// Single-clock show-ahead FIFO with synchronous flush; DEPTH need not be a
// power of two, so pointers wrap explicitly.
module spw_babasu_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 15,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? {AW{1'b0}} : p + AW'(1);
  endfunction

  assign empty     = (count_r == {CW{1'b0}});
  assign full      = (count_r == CW'(DEPTH));
  assign count     = count_r;
  assign pop_data  = mem_r[rd_ptr_r];
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_push_s = push & (~full | pop) & ~flush;
  assign do_pop_s  = pop & ~empty & ~flush;

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (do_pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/spw_babasu_tx_push_port.sv
// Avalon-MM slave that queues software-pushed SpaceWire tokens and presents
// them on the codec txwrite/txrdy handshake through a show-ahead register.
module spw_babasu_tx_push_port
  import spw_babasu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        txwrite,
  output logic        txflag,
  output logic [7:0]  txdata,
  input  logic        txrdy,
  output logic        irq
);

  localparam int FIFO_D = DEPTH - 1;
  localparam int FCW    = $clog2(FIFO_D + 1);

  logic             wr_s;
  logic             push_req_s;
  logic             flush_s;
  logic             ovf_clr_s;
  logic             push_ok_s;
  logic             ovf_set_s;
  logic             handshake_s;
  logic             load_s;
  logic [LVL_W-1:0] level_s;
  logic             full_s;
  logic             empty_s;
  logic [FCW-1:0]   fifo_count_s;
  logic             fifo_empty_s;
  logic             unused_fifo_full_s;
  logic [TOKEN_W-1:0] fifo_head_s;
  token_t           head_s;
  token_t           push_tok_s;
  logic             ovf_r;
  logic [31:0]      status_s;
  logic [31:0]      rd_mux_s;
  logic             unused_s;

  assign wr_s       = chipselect & ~write_n;
  assign push_req_s = wr_s & (address == ADDR_TXDATA);
  assign flush_s    = wr_s & (address == ADDR_FLUSH) & writedata[0];
  assign ovf_clr_s  = wr_s & (address == ADDR_OVF) & writedata[0];
  assign push_tok_s = token_from_word(writedata[TOKEN_W-1:0]);
  assign unused_s   = ^writedata[31:TOKEN_W];

  // Output register counts towards occupancy so full means DEPTH tokens total.
  assign level_s = LVL_W'(fifo_count_s) + LVL_W'(txwrite);
  assign full_s  = (level_s == LVL_W'(DEPTH));
  assign empty_s = (level_s == {LVL_W{1'b0}});

  assign handshake_s = txwrite & txrdy;
  assign push_ok_s   = push_req_s & ~full_s & ~flush_s;
  assign ovf_set_s   = push_req_s & full_s & ~flush_s;
  assign load_s      = ~flush_s & ~fifo_empty_s & (~txwrite | handshake_s);
  assign head_s      = token_t'(fifo_head_s);

  spw_babasu_sync_fifo #(
    .WIDTH (TOKEN_W),
    .DEPTH (FIFO_D)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_ok_s),
    .push_data (push_tok_s),
    .pop       (load_s),
    .flush     (flush_s),
    .pop_data  (fifo_head_s),
    .count     (fifo_count_s),
    .empty     (fifo_empty_s),
    .full      (unused_fifo_full_s)
  );

  // Show-ahead output register towards the codec.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      txwrite <= 1'b0;
      txflag  <= 1'b0;
      txdata  <= 8'h00;
    end else if (flush_s) begin
      txwrite <= 1'b0;
      txflag  <= 1'b0;
      txdata  <= 8'h00;
    end else if (load_s) begin
      txwrite <= 1'b1;
      txflag  <= head_s.flag;
      txdata  <= head_s.data;
    end else if (handshake_s) begin
      txwrite <= 1'b0;
    end
  end

  // Sticky overflow; a new overflow wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= (ovf_r & ~ovf_clr_s) | ovf_set_s;
    end
  end

  assign irq = ovf_r;

  // Status word assembly.
  always_comb begin
    status_s                            = 32'h0000_0000;
    status_s[STAT_EMPTY]                = empty_s;
    status_s[STAT_FULL]                 = full_s;
    status_s[STAT_OVF]                  = ovf_r;
    status_s[STAT_LVL_LSB +: LVL_W]     = level_s;
  end

  // Read mux, decoded from address alone like the RX PIO ports.
  always_comb begin
    rd_mux_s = 32'h0000_0000;
    case (address)
      ADDR_STATUS: rd_mux_s = status_s;
      ADDR_OVF:    rd_mux_s = {31'h0000_0000, ovf_r};
      default:     rd_mux_s = 32'h0000_0000;
    endcase
  end

  // Registered read data, latency one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= 32'h0000_0000;
    end else begin
      readdata <= rd_mux_s;
    end
  end

endmodule

// File: tb/tb_spw_babasu_tx_push_port.sv
// Directed self-checking bench for the SpaceWire TX push port.
module tb_spw_babasu_tx_push_port;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic        txwrite;
  logic        txflag;
  logic [7:0]  txdata;
  logic        txrdy = 1'b0;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spw_babasu_tx_push_port #(.DEPTH(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .txwrite    (txwrite),
    .txflag     (txflag),
    .txdata     (txdata),
    .txrdy      (txrdy),
    .irq        (irq)
  );

  // All tasks start and end 1 time unit after a rising edge.
  task automatic avl_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
  endtask

  task automatic avl_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    @(posedge clk); #1;
    d = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    #12;
    checks++;
    if (txwrite !== 1'b0 || irq !== 1'b0 || readdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs txwrite=%b irq=%b readdata=%h want 0 0 0", txwrite, irq, readdata);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    avl_read(2'd1, d);
    checks++;
    if (d !== 32'h0000_0001) begin
      errors++; $display("FAIL reset_status got %h want 00000001", d);
    end
    checks++;
    if (txwrite !== 1'b0 || irq !== 1'b0) begin
      errors++; $display("FAIL reset_idle txwrite=%b irq=%b want 0 0", txwrite, irq);
    end
  endtask

  task automatic test_order();
    txrdy = 1'b1;
    avl_write(2'd0, 32'h0000_0041);
    checks++;
    if (txwrite !== 1'b0) begin
      errors++; $display("FAIL order_n1 txwrite=%b want 0", txwrite);
    end
    avl_write(2'd0, 32'h0000_01FF);
    checks++;
    if (txwrite !== 1'b1 || txdata !== 8'h41 || txflag !== 1'b0) begin
      errors++; $display("FAIL order_tok0 got w=%b f=%b d=%h want 1 0 41", txwrite, txflag, txdata);
    end
    @(posedge clk); #1;
    checks++;
    if (txwrite !== 1'b1 || txdata !== 8'hFF || txflag !== 1'b1) begin
      errors++; $display("FAIL order_tok1 got w=%b f=%b d=%h want 1 1 ff", txwrite, txflag, txdata);
    end
    @(posedge clk); #1;
    checks++;
    if (txwrite !== 1'b0) begin
      errors++; $display("FAIL order_done txwrite=%b want 0", txwrite);
    end
  endtask

  task automatic test_full_overflow();
    logic [31:0] d;
    int got;
    txrdy = 1'b0;
    for (int i = 0; i < 16; i++) avl_write(2'd0, 32'(i));
    avl_read(2'd1, d);
    checks++;
    if (d !== 32'h0000_1002) begin
      errors++; $display("FAIL full_status got %h want 00001002", d);
    end
    checks++;
    if (txwrite !== 1'b1 || txdata !== 8'h00) begin
      errors++; $display("FAIL full_head w=%b d=%h want 1 00", txwrite, txdata);
    end
    avl_write(2'd0, 32'h0000_00AA);
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL ovf_irq got %b want 1", irq);
    end
    avl_read(2'd1, d);
    checks++;
    if (d !== 32'h0000_1006) begin
      errors++; $display("FAIL ovf_status got %h want 00001006", d);
    end
    avl_read(2'd3, d);
    checks++;
    if (d !== 32'h0000_0001) begin
      errors++; $display("FAIL ovf_reg got %h want 00000001", d);
    end
    txrdy = 1'b1;
    got = 0;
    for (int c = 0; c < 40; c++) begin
      if (txwrite) begin
        checks++;
        if (got >= 16 || txdata !== got[7:0] || txflag !== 1'b0) begin
          errors++; $display("FAIL drain_tok idx=%0d got f=%b d=%h want 0 %h", got, txflag, txdata, got[7:0]);
        end
        got++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (got != 16) begin
      errors++; $display("FAIL drain_count got %0d want 16", got);
    end
    avl_read(2'd1, d);
    checks++;
    if (d !== 32'h0000_0005) begin
      errors++; $display("FAIL drain_status got %h want 00000005", d);
    end
  endtask

  task automatic test_flush();
    logic [31:0] d;
    txrdy = 1'b0;
    for (int i = 0; i < 5; i++) avl_write(2'd0, 32'h150 + 32'(i));
    avl_read(2'd1, d);
    checks++;
    if (d !== 32'h0000_0504) begin
      errors++; $display("FAIL flush_pre_status got %h want 00000504", d);
    end
    checks++;
    if (txwrite !== 1'b1 || txdata !== 8'h50 || txflag !== 1'b1) begin
      errors++; $display("FAIL flush_pre_head w=%b f=%b d=%h want 1 1 50", txwrite, txflag, txdata);
    end
    avl_write(2'd2, 32'h0000_0001);
    checks++;
    if (txwrite !== 1'b0) begin
      errors++; $display("FAIL flush_txwrite got %b want 0", txwrite);
    end
    avl_write(2'd0, 32'h0000_0077);
    avl_read(2'd1, d);
    checks++;
    if (d !== 32'h0000_0104) begin
      errors++; $display("FAIL flush_post_status got %h want 00000104", d);
    end
    checks++;
    if (txwrite !== 1'b1 || txdata !== 8'h77 || txflag !== 1'b0) begin
      errors++; $display("FAIL flush_post_tok w=%b f=%b d=%h want 1 0 77", txwrite, txflag, txdata);
    end
    txrdy = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (txwrite !== 1'b0) begin
      errors++; $display("FAIL flush_post_drain txwrite=%b want 0", txwrite);
    end
  endtask

  task automatic test_ovf_clear();
    logic [31:0] d;
    avl_write(2'd3, 32'h0000_0001);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL clr_irq got %b want 0", irq);
    end
    avl_read(2'd3, d);
    checks++;
    if (d !== 32'h0000_0000) begin
      errors++; $display("FAIL clr_reg got %h want 00000000", d);
    end
    txrdy = 1'b0;
    for (int i = 0; i < 16; i++) avl_write(2'd0, 32'h30 + 32'(i));
    avl_write(2'd0, 32'h0000_00EE);
    avl_write(2'd3, 32'h0000_0001);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL clr_full_irq got %b want 0", irq);
    end
    avl_write(2'd0, 32'h0000_00EF);
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL reovf_irq got %b want 1", irq);
    end
    avl_read(2'd1, d);
    checks++;
    if (d !== 32'h0000_1006) begin
      errors++; $display("FAIL reovf_status got %h want 00001006", d);
    end
    txrdy = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    avl_write(2'd3, 32'h0000_0001);
    avl_read(2'd1, d);
    checks++;
    if (d !== 32'h0000_0001) begin
      errors++; $display("FAIL clr_final_status got %h want 00000001", d);
    end
  endtask

  task automatic test_stall_toggle();
    logic [31:0] d;
    logic [7:0]  exp_d;
    int idx;
    txrdy = 1'b0;
    for (int i = 0; i < 10; i++) avl_write(2'd0, (32'(i % 2) << 8) | (32'h20 + 32'(i)));
    idx = 0;
    for (int c = 0; c < 60; c++) begin
      txrdy = c[0];
      if (txwrite) begin
        exp_d = 8'h20 + idx[7:0];
        checks++;
        if (idx >= 10 || txdata !== exp_d || txflag !== idx[0]) begin
          errors++; $display("FAIL stall_tok idx=%0d got f=%b d=%h want %b %h", idx, txflag, txdata, idx[0], exp_d);
        end
        if (txrdy) idx++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (idx != 10) begin
      errors++; $display("FAIL stall_count got %0d want 10", idx);
    end
    avl_read(2'd1, d);
    checks++;
    if (d !== 32'h0000_0001) begin
      errors++; $display("FAIL stall_status got %h want 00000001", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    txrdy = 1'b0;
    for (int i = 0; i < 3; i++) avl_write(2'd0, 32'h1C0 + 32'(i));
    checks++;
    if (txwrite !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre txwrite=%b want 1", txwrite);
    end
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (txwrite !== 1'b0 || txdata !== 8'h00 || txflag !== 1'b0) begin
      errors++; $display("FAIL rstmid_async w=%b f=%b d=%h want 0 0 00", txwrite, txflag, txdata);
    end
    #10 reset_n = 1'b1;
    @(posedge clk); #1;
    txrdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (txwrite !== 1'b0) begin
        errors++; $display("FAIL rstmid_post cycle=%0d txwrite=%b want 0", c, txwrite);
      end
      @(posedge clk); #1;
    end
    avl_read(2'd1, d);
    checks++;
    if (d !== 32'h0000_0001) begin
      errors++; $display("FAIL rstmid_status got %h want 00000001", d);
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_full_overflow();
    test_flush();
    test_ovf_clear();
    test_stall_toggle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
